// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Optional HAZARD_DETECT_EN adds in-block load-use detection and self-inserted bubbles.
module ex_operand_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [WIDTH-1:0] id_pc,
   input  logic [WIDTH-1:0] id_rs1_data,
   input  logic [WIDTH-1:0] id_rs2_data,
   input  logic [WIDTH-1:0] id_imm,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic [3:0]       id_alu_ctrl,
   input  logic             id_unsign,
   input  logic             id_src_a_pc,
   input  logic             id_src_b_imm,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             id_mem_write,
   input  logic             stall,
   input  logic             flush,
   input  logic [4:0]       mem_rd,
   input  logic             mem_reg_write,
   input  logic [WIDTH-1:0] mem_result,
   input  logic [4:0]       wb_rd,
   input  logic             wb_reg_write,
   input  logic [WIDTH-1:0] wb_result,
   output logic [WIDTH-1:0] ex_a,
   output logic [WIDTH-1:0] ex_b,
   output logic [3:0]       ex_alu_ctrl,
   output logic             ex_unsign,
   output logic [WIDTH-1:0] ex_store_data,
   output logic             ex_valid,
   output logic             ex_reg_write,
   output logic             ex_mem_read,
   output logic             ex_mem_write,
   output logic [4:0]       ex_rd,
   output logic             load_use_stall
);

   typedef struct packed {
      logic             valid;
      logic             reg_write;
      logic             mem_read;
      logic             mem_write;
      logic             unsign;
      logic             src_a_pc;
      logic             src_b_imm;
      logic [3:0]       alu_ctrl;
      logic [4:0]       rd;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] rs1_data;
      logic [WIDTH-1:0] rs2_data;
      logic [WIDTH-1:0] imm;
   } idex_t;

   idex_t            idex_q, idex_d;
   logic             bubble;
   logic [WIDTH-1:0] fwd_rs1, fwd_rs2;

`ifdef HAZARD_DETECT_EN
   assign load_use_stall = idex_q.valid & idex_q.mem_read & id_valid & (idex_q.rd != 5'd0) &
                           ((idex_q.rd == id_rs1) | (idex_q.rd == id_rs2));
`else
   assign load_use_stall = 1'b0;
`endif

   // A detected load-use hazard is handled exactly like an external flush.
   assign bubble = flush | load_use_stall;

   always_comb begin
      idex_d = idex_q;
      if (bubble || !stall) begin
         idex_d.valid     = id_valid;
         idex_d.reg_write = id_valid & id_reg_write;
         idex_d.mem_read  = id_valid & id_mem_read;
         idex_d.mem_write = id_valid & id_mem_write;
         idex_d.unsign    = id_unsign;
         idex_d.src_a_pc  = id_src_a_pc;
         idex_d.src_b_imm = id_src_b_imm;
         idex_d.alu_ctrl  = id_alu_ctrl;
         idex_d.rd        = id_rd;
         idex_d.rs1       = id_rs1;
         idex_d.rs2       = id_rs2;
         idex_d.pc        = id_pc;
         idex_d.rs1_data  = id_rs1_data;
         idex_d.rs2_data  = id_rs2_data;
         idex_d.imm       = id_imm;
      end
      if (bubble) begin
         idex_d.valid     = 1'b0;
         idex_d.reg_write = 1'b0;
         idex_d.mem_read  = 1'b0;
         idex_d.mem_write = 1'b0;
         idex_d.rd        = 5'd0;
         idex_d.alu_ctrl  = 4'b0000;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idex_q <= '0;
      end else begin
         idex_q <= idex_d;
      end
   end

   // MEM beats WB; x0 never forwards. Re-resolved every cycle, including while stalled.
   assign fwd_rs1 = (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == idex_q.rs1)) ? mem_result :
                    (wb_reg_write  && (wb_rd  != 5'd0) && (wb_rd  == idex_q.rs1)) ? wb_result  :
                    idex_q.rs1_data;
   assign fwd_rs2 = (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == idex_q.rs2)) ? mem_result :
                    (wb_reg_write  && (wb_rd  != 5'd0) && (wb_rd  == idex_q.rs2)) ? wb_result  :
                    idex_q.rs2_data;

   assign ex_a          = idex_q.src_a_pc  ? idex_q.pc  : fwd_rs1;
   assign ex_b          = idex_q.src_b_imm ? idex_q.imm : fwd_rs2;
   assign ex_store_data = fwd_rs2;
   assign ex_alu_ctrl   = idex_q.alu_ctrl;
   assign ex_unsign     = idex_q.unsign;
   assign ex_valid      = idex_q.valid;
   assign ex_reg_write  = idex_q.reg_write;
   assign ex_mem_read   = idex_q.mem_read;
   assign ex_mem_write  = idex_q.mem_write;
   assign ex_rd         = idex_q.rd;

endmodule
